// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input mapper: sequencer states,
// CSJUDLR bit positions, PS/2 scancodes and the rotation remap.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COIN,
        GAP,
        START
    } seq_state_t;

    localparam int BIT_R = 0;
    localparam int BIT_L = 1;
    localparam int BIT_D = 2;
    localparam int BIT_U = 3;
    localparam int BIT_J = 4;
    localparam int BIT_S = 5;
    localparam int BIT_C = 6;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [8:0] SC_FIRE_A = 9'h029;
    localparam logic [8:0] SC_FIRE_B = 9'h014;
    localparam logic [8:0] SC_COIN   = 9'h02E;
    // Index i is the start key for player i.
    localparam logic [3:0][8:0] SC_START = {9'h00C, 9'h004, 9'h006, 9'h005};

    // Operates on {U,D,L,R}; each output direction picks one source direction.
    function automatic logic [3:0] rotate_udlr(input logic [3:0] udlr, input logic [1:0] rot);
        logic u, d, l, r;
        {u, d, l, r} = udlr;
        case (rot)
            2'd1:    rotate_udlr = {l, r, d, u};
            2'd2:    rotate_udlr = {d, u, r, l};
            2'd3:    rotate_udlr = {r, l, u, d};
            default: rotate_udlr = udlr;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_decode.sv
// Turns hps_io PS/2 key events into held key-state registers for the
// directions, fire, coin and the four per-player start keys.
module ps2_key_decode
    import arcade_input_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [64:0] ps2_key,
    output logic        key_up,
    output logic        key_down,
    output logic        key_left,
    output logic        key_right,
    output logic        key_fire,
    output logic        key_coin,
    output logic [3:0]  key_start
);

    logic       old_tog_reg;
    logic       key_up_reg;
    logic       key_down_reg;
    logic       key_left_reg;
    logic       key_right_reg;
    logic       key_fire_reg;
    logic       key_coin_reg;
    logic [3:0] key_start_reg;

    logic       pressed;
    logic       extended;
    logic       key_event;
    logic [8:0] code;

    always_comb begin
        pressed   = (ps2_key[15:8] != SC_BREAK);
        extended  = pressed ? (ps2_key[15:8] == SC_EXT) : (ps2_key[23:16] == SC_EXT);
        code      = {extended, ps2_key[7:0]};
        // Anything in the high bytes is a multi-byte sequence we do not map.
        if (ps2_key[63:24] != '0) begin
            code = '0;
        end
        key_event = (ps2_key[64] != old_tog_reg);
    end

    // The toggle tracker also loads during reset so release creates no event.
    always_ff @(posedge clk_sys) begin
        old_tog_reg <= ps2_key[64];
        if (!reset_n) begin
            key_up_reg    <= 1'b0;
            key_down_reg  <= 1'b0;
            key_left_reg  <= 1'b0;
            key_right_reg <= 1'b0;
            key_fire_reg  <= 1'b0;
            key_coin_reg  <= 1'b0;
            key_start_reg <= '0;
        end else if (key_event) begin
            if (code[7:0] == SC_UP)    key_up_reg    <= pressed;
            if (code[7:0] == SC_DOWN)  key_down_reg  <= pressed;
            if (code[7:0] == SC_LEFT)  key_left_reg  <= pressed;
            if (code[7:0] == SC_RIGHT) key_right_reg <= pressed;
            if (code == SC_FIRE_A || code == SC_FIRE_B) key_fire_reg <= pressed;
            if (code == SC_COIN) key_coin_reg <= pressed;
            for (int i = 0; i < 4; i++) begin
                if (code == SC_START[i]) key_start_reg[i] <= pressed;
            end
        end
    end

    assign key_up    = key_up_reg;
    assign key_down  = key_down_reg;
    assign key_left  = key_left_reg;
    assign key_right = key_right_reg;
    assign key_fire  = key_fire_reg;
    assign key_coin  = key_coin_reg;
    assign key_start = key_start_reg;

endmodule

// File: rtl/arcade_input_map.sv
// Merges PS/2 keys and joysticks into per-player CSJUDLR vectors with rotation,
// autofire and a coin/start sequencer that inserts k+1 coins for player k.
module arcade_input_map
    import arcade_input_pkg::*;
#(
    parameter int NPLAYERS     = 2,
    parameter int COIN_CYCLES  = 600000,
    parameter int GAP_CYCLES   = 600000,
    parameter int START_CYCLES = 600000,
    parameter int AF_DIV       = 400000
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [64:0]             ps2_key,
    input  logic [16*NPLAYERS-1:0]  joystick,
    input  logic [1:0]              rotate,
    input  logic                    autofire_en,
    input  logic                    shared_joy,
    output logic [7*NPLAYERS-1:0]   p_csjudlr,
    output logic                    busy
);

    localparam int SEQ_MAX_CG = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
    localparam int SEQ_MAX    = (SEQ_MAX_CG > START_CYCLES) ? SEQ_MAX_CG : START_CYCLES;
    localparam int CNT_W      = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int AF_W       = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    localparam int PW         = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;

    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [AF_W-1:0]  AF_LAST    = AF_W'(AF_DIV - 1);

    logic       key_up, key_down, key_left, key_right, key_fire, key_coin;
    logic [3:0] key_start;

    ps2_key_decode u_key_decode (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_fire  (key_fire),
        .key_coin  (key_coin),
        .key_start (key_start)
    );

    logic [NPLAYERS-1:0][4:0] raw_joy;
    logic [4:0]               or_joy;
    logic [NPLAYERS-1:0]      start_lvl;
    logic [NPLAYERS-1:0]      start_prev_reg;
    logic [NPLAYERS-1:0]      start_rise;
    logic [NPLAYERS-1:0]      pend_reg;
    logic [NPLAYERS-1:0]      pend_next;
    logic [NPLAYERS-1:0]      seq_start_reg;
    logic                     seq_coin_reg;
    seq_state_t               state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [1:0]               coins_left_reg;
    logic [PW-1:0]            player_reg;
    logic [PW-1:0]            sel_idx;
    logic [AF_W-1:0]          af_cnt_reg;
    logic                     af_phase_reg;
    logic [7*NPLAYERS-1:0]    p_next;

    genvar gi;
    generate
        for (gi = 0; gi < NPLAYERS; gi++) begin : g_player
            logic [4:0] merged;
            logic [3:0] dirs;
            logic       fire_out;
            logic       coin_out;

            // Keyboard directions and fire belong to player 0 only.
            if (gi == 0) begin : g_keys
                assign raw_joy[gi] = joystick[4:0] |
                                     {key_fire, key_up, key_down, key_left, key_right};
                assign coin_out    = seq_coin_reg | key_coin;
            end else begin : g_nokeys
                assign raw_joy[gi] = joystick[16*gi +: 5];
                assign coin_out    = 1'b0;
            end
            assign start_lvl[gi] = joystick[16*gi + 5] | key_start[gi];

            assign merged   = shared_joy ? or_joy : raw_joy[gi];
            assign dirs     = rotate_udlr(merged[3:0], rotate);
            assign fire_out = autofire_en ? (merged[4] & af_phase_reg) : merged[4];
            assign p_next[7*gi +: 7] = {coin_out, seq_start_reg[gi], fire_out, dirs};
        end
    endgenerate

    always_comb begin
        or_joy = '0;
        for (int i = 0; i < NPLAYERS; i++) begin
            or_joy = or_joy | raw_joy[i];
        end
    end

    // Lowest pending player wins; searching downwards leaves it last written.
    always_comb begin
        sel_idx = '0;
        for (int i = NPLAYERS - 1; i >= 0; i--) begin
            if (pend_reg[i]) sel_idx = PW'(i);
        end
    end

    assign start_rise = start_lvl & ~start_prev_reg;

    always_comb begin
        pend_next = pend_reg;
        if (state_reg == IDLE && pend_reg != '0) begin
            pend_next[sel_idx] = 1'b0;
        end
        pend_next = pend_next | start_rise;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            coins_left_reg <= '0;
            player_reg     <= '0;
            pend_reg       <= '0;
            start_prev_reg <= '0;
            seq_coin_reg   <= 1'b0;
            seq_start_reg  <= '0;
        end else begin
            start_prev_reg <= start_lvl;
            pend_reg       <= pend_next;
            case (state_reg)
                IDLE: begin
                    if (pend_reg != '0) begin
                        coins_left_reg <= 2'(sel_idx);
                        player_reg     <= sel_idx;
                        cnt_reg        <= '0;
                        seq_coin_reg   <= 1'b1;
                        state_reg      <= COIN;
                    end
                end
                COIN: begin
                    if (cnt_reg == COIN_LAST) begin
                        cnt_reg      <= '0;
                        seq_coin_reg <= 1'b0;
                        state_reg    <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg <= '0;
                        if (coins_left_reg != 2'd0) begin
                            coins_left_reg <= coins_left_reg - 2'd1;
                            seq_coin_reg   <= 1'b1;
                            state_reg      <= COIN;
                        end else begin
                            seq_start_reg <= NPLAYERS'(1) << player_reg;
                            state_reg     <= START;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                START: begin
                    if (cnt_reg == START_LAST) begin
                        cnt_reg       <= '0;
                        seq_start_reg <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    cnt_reg       <= '0;
                    seq_coin_reg  <= 1'b0;
                    seq_start_reg <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            af_cnt_reg   <= '0;
            af_phase_reg <= 1'b0;
        end else if (af_cnt_reg == AF_LAST) begin
            af_cnt_reg   <= '0;
            af_phase_reg <= ~af_phase_reg;
        end else begin
            af_cnt_reg <= af_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            p_csjudlr <= '0;
        end else begin
            p_csjudlr <= p_next;
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_arcade_input_map.sv
// Directed bench for arcade_input_map: key decode/rotation, joystick merge,
// autofire and the coin/start sequencer including queueing and mid-run reset.
module tb_arcade_input_map;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic [31:0] joystick;
    logic [1:0]  rotate;
    logic        autofire_en;
    logic        shared_joy;
    logic [13:0] p_csjudlr;
    logic        busy;
    logic        tog;

    int tests_run    = 0;
    int tests_failed = 0;

    arcade_input_map #(
        .NPLAYERS     (2),
        .COIN_CYCLES  (4),
        .GAP_CYCLES   (3),
        .START_CYCLES (5),
        .AF_DIV       (2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .joystick    (joystick),
        .rotate      (rotate),
        .autofire_en (autofire_en),
        .shared_joy  (shared_joy),
        .p_csjudlr   (p_csjudlr),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic send_key(input logic [63:0] body);
        tog     = ~tog;
        ps2_key = {tog, body};
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        tog         = 1'b1;
        ps2_key     = {1'b1, 64'h0};
        joystick    = '0;
        rotate      = 2'd0;
        autofire_en = 1'b0;
        shared_joy  = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            tests_run++;
            if (p_csjudlr !== 14'h0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle cyc=%0d got p=%h busy=%b want p=0000 busy=0", i, p_csjudlr, busy);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_key_rotate();
        logic [63:0] kp   [9] = '{64'h6B, 64'h75, 64'h75, 64'hE074, 64'h72,
                                  64'h29, 64'h14, 64'h2E, 64'h4000_0075};
        logic [63:0] kr   [9] = '{64'hF06B, 64'hF075, 64'hF075, 64'hE0F074, 64'hF072,
                                  64'hF029, 64'hF014, 64'hF02E, 64'h4000_F075};
        logic [1:0]  krot [9] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [13:0] kexp [9] = '{14'h0002, 14'h0004, 14'h0002, 14'h0001, 14'h0002,
                                  14'h0010, 14'h0010, 14'h0040, 14'h0000};
        rotate = 2'd1;
        send_key(64'h75);
        @(negedge clk_sys);
        tests_run++;
        if (p_csjudlr !== 14'h0) begin
            tests_failed++;
            $display("FAIL key_latency1 got p=%h want 0000", p_csjudlr);
        end
        @(negedge clk_sys);
        tests_run++;
        if (p_csjudlr !== 14'h0001) begin
            tests_failed++;
            $display("FAIL key_up_rot1 got p=%h want 0001", p_csjudlr);
        end
        send_key(64'hF075);
        repeat (2) @(negedge clk_sys);
        tests_run++;
        if (p_csjudlr !== 14'h0) begin
            tests_failed++;
            $display("FAIL key_up_release got p=%h want 0000", p_csjudlr);
        end
        for (int i = 0; i < 9; i++) begin
            rotate = krot[i];
            send_key(kp[i]);
            repeat (2) @(negedge clk_sys);
            tests_run++;
            if (p_csjudlr !== kexp[i]) begin
                tests_failed++;
                $display("FAIL key_press[%0d] key=%h rot=%0d got p=%h want %h", i, kp[i], krot[i], p_csjudlr, kexp[i]);
            end
            send_key(kr[i]);
            repeat (2) @(negedge clk_sys);
            tests_run++;
            if (p_csjudlr !== 14'h0) begin
                tests_failed++;
                $display("FAIL key_release[%0d] key=%h got p=%h want 0000", i, kr[i], p_csjudlr);
            end
        end
        rotate = 2'd0;
        $display("[TB] test_key_rotate done");
    endtask

    task automatic test_joystick_shared();
        joystick[19] = 1'b1;
        @(negedge clk_sys);
        tests_run++;
        if (p_csjudlr !== 14'h0400) begin
            tests_failed++;
            $display("FAIL joy_p1_up got p=%h want 0400", p_csjudlr);
        end
        shared_joy = 1'b1;
        @(negedge clk_sys);
        tests_run++;
        if (p_csjudlr !== 14'h0408) begin
            tests_failed++;
            $display("FAIL joy_shared got p=%h want 0408", p_csjudlr);
        end
        joystick   = '0;
        shared_joy = 1'b0;
        @(negedge clk_sys);
        tests_run++;
        if (p_csjudlr !== 14'h0) begin
            tests_failed++;
            $display("FAIL joy_release got p=%h want 0000", p_csjudlr);
        end
        $display("[TB] test_joystick_shared done");
    endtask

    task automatic test_seq_single();
        int          waited;
        logic [13:0] want;
        joystick[21] = 1'b1;
        @(negedge clk_sys);
        joystick[21] = 1'b0;
        waited = 0;
        while (p_csjudlr[6] !== 1'b1 && waited < 10) begin
            @(negedge clk_sys);
            waited++;
        end
        tests_run++;
        if (p_csjudlr[6] !== 1'b1) begin
            tests_failed++;
            $display("FAIL seq1_coin_timeout got p=%h want C0=1", p_csjudlr);
            return;
        end
        for (int i = 0; i < 19; i++) begin
            want = '0;
            want[6]  = (i < 4) || (i >= 7 && i < 11);
            want[12] = (i >= 14);
            tests_run++;
            if (p_csjudlr !== want) begin
                tests_failed++;
                $display("FAIL seq1_pattern step=%0d got p=%h want %h", i, p_csjudlr, want);
            end
            if (i == 0 || i == 14) begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL seq1_busy step=%0d got %b want 1", i, busy);
                end
            end
            @(negedge clk_sys);
        end
        tests_run++;
        if (p_csjudlr !== 14'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq1_end got p=%h busy=%b want p=0000 busy=0", p_csjudlr, busy);
        end
        $display("[TB] test_seq_single done");
    endtask

    task automatic test_seq_queue();
        int          waited;
        logic [13:0] want;
        joystick[5] = 1'b1;
        @(negedge clk_sys);
        joystick[5] = 1'b0;
        waited = 0;
        while (p_csjudlr[6] !== 1'b1 && waited < 10) begin
            @(negedge clk_sys);
            waited++;
        end
        tests_run++;
        if (p_csjudlr[6] !== 1'b1) begin
            tests_failed++;
            $display("FAIL seq2_coin_timeout got p=%h want C0=1", p_csjudlr);
            return;
        end
        for (int i = 0; i < 32; i++) begin
            want = '0;
            want[6]  = (i < 4) || (i >= 13 && i < 17) || (i >= 20 && i < 24);
            want[5]  = (i >= 7 && i < 12);
            want[12] = (i >= 27);
            tests_run++;
            if (p_csjudlr !== want) begin
                tests_failed++;
                $display("FAIL seq2_pattern step=%0d got p=%h want %h", i, p_csjudlr, want);
            end
            if (i == 11 || i == 12) begin
                tests_run++;
                if (busy !== (i == 12)) begin
                    tests_failed++;
                    $display("FAIL seq2_busy step=%0d got %b want %b", i, busy, (i == 12));
                end
            end
            if (i == 0) send_key(64'h06);
            if (i == 3) send_key(64'hF006);
            @(negedge clk_sys);
        end
        tests_run++;
        if (p_csjudlr !== 14'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq2_end got p=%h busy=%b want p=0000 busy=0", p_csjudlr, busy);
        end
        $display("[TB] test_seq_queue done");
    endtask

    task automatic test_autofire();
        logic j [10];
        autofire_en = 1'b1;
        joystick[4] = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 10; i++) begin
            j[i] = p_csjudlr[4];
            @(negedge clk_sys);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (j[i+2] !== ~j[i]) begin
                tests_failed++;
                $display("FAIL autofire_toggle idx=%0d got J=%b want %b", i + 2, j[i+2], ~j[i]);
            end
        end
        autofire_en = 1'b0;
        @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (p_csjudlr !== 14'h0010) begin
                tests_failed++;
                $display("FAIL autofire_off cyc=%0d got p=%h want 0010", i, p_csjudlr);
            end
            @(negedge clk_sys);
        end
        joystick = '0;
        repeat (2) @(negedge clk_sys);
        $display("[TB] test_autofire done");
    endtask

    task automatic test_reset_mid();
        int waited;
        joystick[21] = 1'b1;
        @(negedge clk_sys);
        joystick[21] = 1'b0;
        waited = 0;
        while (p_csjudlr[6] !== 1'b1 && waited < 10) begin
            @(negedge clk_sys);
            waited++;
        end
        joystick[5] = 1'b1;
        @(negedge clk_sys);
        joystick[5] = 1'b0;
        waited = 0;
        while (p_csjudlr[6] !== 1'b0 && waited < 10) begin
            @(negedge clk_sys);
            waited++;
        end
        tests_run++;
        if (p_csjudlr[6] !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_gap_reach got p=%h busy=%b want C0=0 busy=1", p_csjudlr, busy);
        end
        reset_n = 1'b0;
        @(negedge clk_sys);
        tests_run++;
        if (p_csjudlr !== 14'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_clear got p=%h busy=%b want p=0000 busy=0", p_csjudlr, busy);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            tests_run++;
            if (p_csjudlr !== 14'h0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstmid_after cyc=%0d got p=%h busy=%b want p=0000 busy=0", i, p_csjudlr, busy);
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_key_rotate();
        test_joystick_shared();
        test_seq_single();
        test_seq_queue();
        test_autofire();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
